// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width default and FSM state encoding.
package spi_pkg;

   localparam int unsigned SPI_DATA_W = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_TAIL  = 2'd3
   } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with rise/fall edge detect on the synchronized level.
module spi_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // Synchronizer chain plus one history flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < int'(STAGES); i++) begin
            chain[i] <= chain[i-1];
         end
         prev <= chain[STAGES-1];
      end
   end

   assign q      = chain[STAGES-1];
   assign rise_c = q & ~prev;
   assign fall_c = ~q & prev;

endmodule

// File: rtl/spi_rx.sv
// SPI slave receiver: one lead-in bit, then DATA_W bits LSB first, sampled on sclk fall.
module spi_rx
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = SPI_DATA_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs,
   input  logic              mosi,
   output logic [DATA_W-1:0] dout,
   output logic              done,
   output logic              err
);

   localparam int unsigned      CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

   logic                   sclk_q_unused;
   logic                   sclk_rise_unused;
   logic                   sclk_fall;
   logic                   cs_q;
   logic                   cs_rise;
   logic                   cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   mosi_q;
   logic [SYNC_STAGES:0]   settle;

   spi_state_t             state;
   logic [CNT_W-1:0]       count;
   logic [DATA_W-1:0]      sreg;
   logic                   ovr;
   logic                   armed;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk    (clk),
      .rst    (rst),
      .d      (sclk),
      .q      (sclk_q_unused),
      .rise_c (sclk_rise_unused),
      .fall_c (sclk_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk    (clk),
      .rst    (rst),
      .d      (cs),
      .q      (cs_q),
      .rise_c (cs_rise),
      .fall_c (cs_fall)
   );

   // Data line needs only the level synchronizer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mosi_sync <= {SYNC_STAGES{1'b1}};
      end else begin
         mosi_sync[0] <= mosi;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            mosi_sync[i] <= mosi_sync[i-1];
         end
      end
   end

   assign mosi_q = mosi_sync[SYNC_STAGES-1];

   // Marks when the cs chain holds real samples rather than its reset fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle <= '0;
      end else begin
         settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // Frame FSM with shift register, overrun tracking and registered pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         count <= '0;
         sreg  <= '0;
         dout  <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
         ovr   <= 1'b0;
         armed <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (settle[SYNC_STAGES] && cs_q) begin
            armed <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (cs_fall && armed) begin
                  state <= ST_LEAD;
                  count <= '0;
                  ovr   <= 1'b0;
               end
            end
            ST_LEAD: begin
               if (cs_rise) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end else if (sclk_fall) begin
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (cs_rise) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end else if (sclk_fall) begin
                  sreg[count] <= mosi_q;
                  if (count == LAST) begin
                     state <= ST_TAIL;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            ST_TAIL: begin
               if (cs_rise) begin
                  dout  <= sreg;
                  done  <= 1'b1;
                  err   <= ovr;
                  state <= ST_IDLE;
               end else if (sclk_fall) begin
                  ovr <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_rx.sv
// Testbench for spi_rx: vector table of frames plus reset and idle-sclk sequences.
module tb_spi_rx;

   typedef struct {
      logic [11:0] data;
      int          nbits;
      int          extra;
      int          hp;
      logic        exp_done;
      logic        exp_err;
      logic [11:0] exp_dout;
   } vec_t;

   typedef struct packed {
      logic        done;
      logic        err;
      logic [11:0] dout;
   } ev_t;

   logic        clk;
   logic        rst;
   logic        sclk;
   logic        cs;
   logic        mosi;
   logic [11:0] dout;
   logic        done;
   logic        err;

   int          checks;
   int          errors;
   ev_t         sb[$];
   vec_t        vecs[8];
   logic        prev_done;
   logic        prev_err;

   spi_rx #(.DATA_W(12), .SYNC_STAGES(2)) dut (
      .clk  (clk),
      .rst  (rst),
      .sclk (sclk),
      .cs   (cs),
      .mosi (mosi),
      .dout (dout),
      .done (done),
      .err  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One master frame: lead-in bit, nbits data bits, extra junk periods, then cs rise.
   task automatic send_frame(input logic [11:0] data, input int nbits, input int extra, input int hp);
      logic [11:0] d;
      d = data;
      cs = 1'b0;
      tick(hp);
      sclk = 1'b1; mosi = d[0]; tick(hp);
      sclk = 1'b0; tick(hp);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1; mosi = d[i]; tick(hp);
         sclk = 1'b0; tick(hp);
      end
      for (int i = 0; i < extra; i++) begin
         sclk = 1'b1; mosi = 1'($urandom); tick(hp);
         sclk = 1'b0; tick(hp);
      end
      tick(hp);
      cs = 1'b1;
      tick(4 * hp + 8);
   endtask

   // Scoreboard monitor: every done/err pulse must match the next expected event.
   always @(negedge clk) begin
      if (rst) begin
         prev_done <= 1'b0;
         prev_err  <= 1'b0;
      end else begin
         if (done || err) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
            end else begin
               ev_t e;
               e = sb.pop_front();
               chk("sb_done", 32'(done), 32'(e.done));
               chk("sb_err", 32'(err), 32'(e.err));
               chk("sb_dout", 32'(dout), 32'(e.dout));
            end
            if (done) chk("done_single", 32'(prev_done), 32'd0);
            if (err)  chk("err_single", 32'(prev_err), 32'd0);
         end
         prev_done <= done;
         prev_err  <= err;
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      rst  = 1'b1;
      sclk = 1'b0;
      cs   = 1'b1;
      mosi = 1'b1;

      vecs[0] = '{12'hA5C, 12, 0, 4, 1'b1, 1'b0, 12'hA5C};
      vecs[1] = '{12'h001, 12, 0, 4, 1'b1, 1'b0, 12'h001};
      vecs[2] = '{12'hFFF, 12, 0, 4, 1'b1, 1'b0, 12'hFFF};
      vecs[3] = '{12'hA5C, 12, 0, 3, 1'b1, 1'b0, 12'hA5C};
      vecs[4] = '{12'h123,  6, 0, 4, 1'b0, 1'b1, 12'hA5C};
      vecs[5] = '{12'h5A5, 12, 2, 4, 1'b1, 1'b1, 12'h5A5};
      vecs[6] = '{12'h0F0,  0, 0, 5, 1'b0, 1'b1, 12'h5A5};
      vecs[7] = '{12'h800, 12, 0, 3, 1'b1, 1'b0, 12'h800};

      tick(3);
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      rst = 1'b0;
      tick(10);

      for (int v = 0; v < 8; v++) begin
         if (vecs[v].exp_done || vecs[v].exp_err) begin
            sb.push_back('{vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_dout});
         end
         send_frame(vecs[v].data, vecs[v].nbits, vecs[v].extra, vecs[v].hp);
         chk($sformatf("vec%0d_dout", v), 32'(dout), 32'(vecs[v].exp_dout));
         chk($sformatf("vec%0d_sb_drained", v), 32'(sb.size()), 32'd0);
      end

      // Reset in the middle of a frame, released while cs is still low.
      cs = 1'b0;
      tick(4);
      sclk = 1'b1; mosi = 1'b1; tick(4);
      sclk = 1'b0; tick(4);
      for (int i = 0; i < 5; i++) begin
         sclk = 1'b1; mosi = 1'(i & 1); tick(4);
         sclk = 1'b0; tick(4);
      end
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      chk("midrst_dout", 32'(dout), 32'd0);
      for (int i = 0; i < 8; i++) begin
         sclk = 1'b1; mosi = 1'(i & 1); tick(4);
         sclk = 1'b0; tick(4);
      end
      tick(4);
      cs = 1'b1;
      tick(12);
      chk("midrst_no_frame", 32'(dout), 32'd0);
      sb.push_back('{1'b1, 1'b0, 12'h3C3});
      send_frame(12'h3C3, 12, 0, 4);
      chk("post_rst_dout", 32'(dout), 32'h3C3);

      // sclk activity with cs high must be ignored.
      for (int i = 0; i < 20; i++) begin
         sclk = 1'b1; mosi = 1'($urandom); tick(4);
         sclk = 1'b0; tick(4);
      end
      tick(10);
      chk("idle_sclk_dout", 32'(dout), 32'h3C3);

      tick(20);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
